// File: rtl/ram_arbiter.sv
// Two-master (cpu/dbg) sequencer for the RAM: IDLE -> ADDR -> DATA, one access per 3 clocks.
// Build option: RAM_ARB_CPU_PRIORITY_EN selects fixed cpu priority instead of round-robin.
module ram_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_nReset,
  input  logic                  i_cpuReq,
  input  logic                  i_cpuWe,
  input  logic                  i_cpuSel,
  input  logic [ADDR_WIDTH-1:0] i_cpuAddr,
  input  logic [DATA_WIDTH-1:0] i_cpuWData,
  output logic                  o_cpuGnt,
  output logic                  o_cpuDone,
  output logic                  o_cpuErr,
  output logic [DATA_WIDTH-1:0] o_cpuRData,
  input  logic                  i_dbgReq,
  input  logic                  i_dbgWe,
  input  logic                  i_dbgSel,
  input  logic [ADDR_WIDTH-1:0] i_dbgAddr,
  input  logic [DATA_WIDTH-1:0] i_dbgWData,
  output logic                  o_dbgGnt,
  output logic                  o_dbgDone,
  output logic                  o_dbgErr,
  output logic [DATA_WIDTH-1:0] o_dbgRData,
  output logic [ADDR_WIDTH-1:0] o_ramAddress,
  output logic                  o_ramAddressEn,
  output logic [DATA_WIDTH-1:0] o_ramWriteData,
  output logic                  o_ramWriteEn,
  output logic                  o_ramReadDataSelect,
  output logic                  o_ramOutEnable,
  input  logic [DATA_WIDTH-1:0] i_ramReadData
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  we_q, we_d;
  logic                  sel_q, sel_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_WIDTH-1:0] dbg_rdata_q, dbg_rdata_d;
  logic                  cpu_done_q, cpu_done_d;
  logic                  cpu_err_q, cpu_err_d;
  logic                  dbg_done_q, dbg_done_d;
  logic                  dbg_err_q, dbg_err_d;
  logic                  cpu_win, dbg_win;

`ifndef RAM_ARB_CPU_PRIORITY_EN
  // prio_q = 0: cpu wins the next tie, 1: dbg wins it
  logic                  prio_q, prio_d;
`endif

  always_comb begin
    cpu_win = 1'b0;
    dbg_win = 1'b0;
    if (i_nReset && state_q == S_IDLE) begin
`ifdef RAM_ARB_CPU_PRIORITY_EN
      cpu_win = i_cpuReq;
      dbg_win = i_dbgReq & ~i_cpuReq;
`else
      cpu_win = i_cpuReq & (~i_dbgReq | ~prio_q);
      dbg_win = i_dbgReq & (~i_cpuReq | prio_q);
`endif
    end
  end

`ifndef RAM_ARB_CPU_PRIORITY_EN
  always_comb begin
    prio_d = prio_q;
    if (cpu_win) prio_d = 1'b1;
    else if (dbg_win) prio_d = 1'b0;
  end
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    cpu_done_d  = 1'b0;
    cpu_err_d   = 1'b0;
    dbg_done_d  = 1'b0;
    dbg_err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cpu_win) begin
          state_d = S_ADDR;
          owner_d = 1'b0;
          we_d    = i_cpuWe;
          sel_d   = i_cpuSel;
          addr_d  = i_cpuAddr;
          wdata_d = i_cpuWData;
        end else if (dbg_win) begin
          state_d = S_ADDR;
          owner_d = 1'b1;
          we_d    = i_dbgWe;
          sel_d   = i_dbgSel;
          addr_d  = i_dbgAddr;
          wdata_d = i_dbgWData;
        end
      end
      S_ADDR: state_d = S_DATA;
      S_DATA: begin
        state_d = S_IDLE;
        if (owner_q) begin
          dbg_done_d = 1'b1;
          dbg_err_d  = we_q & ~sel_q;
          if (!we_q) dbg_rdata_d = i_ramReadData;
        end else begin
          cpu_done_d = 1'b1;
          cpu_err_d  = we_q & ~sel_q;
          if (!we_q) cpu_rdata_d = i_ramReadData;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nReset) begin
    if (!i_nReset) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      cpu_done_q  <= 1'b0;
      cpu_err_q   <= 1'b0;
      dbg_done_q  <= 1'b0;
      dbg_err_q   <= 1'b0;
`ifndef RAM_ARB_CPU_PRIORITY_EN
      prio_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
      cpu_done_q  <= cpu_done_d;
      cpu_err_q   <= cpu_err_d;
      dbg_done_q  <= dbg_done_d;
      dbg_err_q   <= dbg_err_d;
`ifndef RAM_ARB_CPU_PRIORITY_EN
      prio_q      <= prio_d;
`endif
    end
  end

  // program-section writes are dropped: no strobe, only Err
  assign o_cpuGnt            = cpu_win;
  assign o_dbgGnt            = dbg_win;
  assign o_cpuDone           = cpu_done_q;
  assign o_cpuErr            = cpu_err_q;
  assign o_cpuRData          = cpu_rdata_q;
  assign o_dbgDone           = dbg_done_q;
  assign o_dbgErr            = dbg_err_q;
  assign o_dbgRData          = dbg_rdata_q;
  assign o_ramAddress        = addr_q;
  assign o_ramAddressEn      = (state_q == S_ADDR);
  assign o_ramWriteEn        = (state_q == S_DATA) & we_q & sel_q;
  assign o_ramWriteData      = o_ramWriteEn ? wdata_q : '0;
  assign o_ramOutEnable      = (state_q == S_DATA) & ~we_q;
  assign o_ramReadDataSelect = (state_q == S_DATA) & (sel_q | we_q);

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomised scoreboard bench for ram_arbiter with a behavioural RAM and
// an access-level reference model (arbitration, memory contents, timing).
module tb_ram_arbiter;

  typedef struct packed {
    logic       we;
    logic       sel;
    logic [7:0] addr;
    logic [7:0] data;
  } req_t;

  typedef struct packed {
    logic        own;
    logic        err;
    logic        rdv;
    logic [7:0]  rd;
    logic [31:0] cyc;
  } exp_t;

`ifdef RAM_ARB_CPU_PRIORITY_EN
  localparam bit CPU_PRIO = 1'b1;
`else
  localparam bit CPU_PRIO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req, we, sel;
  logic [7:0] addr [2];
  logic [7:0] wd [2];
  logic       cpu_gnt, dbg_gnt, cpu_done, dbg_done, cpu_err, dbg_err;
  logic [7:0] cpu_rd, dbg_rd;
  logic [7:0] ram_a, ram_wd, ram_rd, ram_areg;
  logic       ram_ae, ram_we, ram_rsel, ram_oe;
  logic [1:0] gnt, done, err;
  logic [41:0] all_outs;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rate = 100;
  bit [1:0] gseen = 2'b00;
  req_t pq0[$];
  req_t pq1[$];
  exp_t expq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_arbiter dut (
    .i_clk(clk), .i_nReset(rst_n),
    .i_cpuReq(req[0]), .i_cpuWe(we[0]), .i_cpuSel(sel[0]),
    .i_cpuAddr(addr[0]), .i_cpuWData(wd[0]),
    .o_cpuGnt(cpu_gnt), .o_cpuDone(cpu_done), .o_cpuErr(cpu_err),
    .o_cpuRData(cpu_rd),
    .i_dbgReq(req[1]), .i_dbgWe(we[1]), .i_dbgSel(sel[1]),
    .i_dbgAddr(addr[1]), .i_dbgWData(wd[1]),
    .o_dbgGnt(dbg_gnt), .o_dbgDone(dbg_done), .o_dbgErr(dbg_err),
    .o_dbgRData(dbg_rd),
    .o_ramAddress(ram_a), .o_ramAddressEn(ram_ae),
    .o_ramWriteData(ram_wd), .o_ramWriteEn(ram_we),
    .o_ramReadDataSelect(ram_rsel), .o_ramOutEnable(ram_oe),
    .i_ramReadData(ram_rd)
  );

  assign gnt  = {dbg_gnt, cpu_gnt};
  assign done = {dbg_done, cpu_done};
  assign err  = {dbg_err, cpu_err};
  assign all_outs = {gnt, done, err, cpu_rd, dbg_rd, ram_a, ram_ae,
                     ram_wd, ram_we, ram_rsel, ram_oe};

  function automatic logic [7:0] init_f(input logic [7:0] a);
    return a * 8'd37 + 8'd11;
  endfunction

  function automatic logic [7:0] prog_f(input logic [7:0] a);
    return a ^ 8'hC3;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // behavioural RAM: registered address, data section writable, program fixed
  logic [7:0] ram_data [256];
  bit ram_ok = 1'b0;
  always @(posedge clk) begin
    if (!ram_ok) begin
      for (int i = 0; i < 256; i++) ram_data[i] <= init_f(8'(i));
      ram_ok <= 1'b1;
    end else if (ram_we) begin
      ram_data[ram_areg] <= ram_wd;
    end
    if (ram_ae) ram_areg <= ram_a;
  end
  assign ram_rd = ram_oe ? (ram_rsel ? ram_data[ram_areg] : prog_f(ram_areg))
                         : 8'h00;

  function automatic req_t qpop(input int i);
    if (i == 0) return pq0.pop_front();
    return pq1.pop_front();
  endfunction

  function automatic int qsize(input int i);
    if (i == 0) return pq0.size();
    return pq1.size();
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++)
      if (rst_n && req[i] && gnt[i]) gseen[i] = 1'b1;
  end

  // requester drivers: hold Req with fields until granted
  initial begin
    req_t r;
    req = 2'b00; we = 2'b00; sel = 2'b00;
    addr[0] = 0; addr[1] = 0; wd[0] = 0; wd[1] = 0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          req[i] = 1'b0;
          gseen[i] = 1'b0;
        end else begin
          if (req[i] && gseen[i]) begin
            req[i] = 1'b0;
            gseen[i] = 1'b0;
          end
          if (!req[i] && qsize(i) > 0 && $urandom_range(99) < rate) begin
            r = qpop(i);
            we[i] = r.we; sel[i] = r.sel; addr[i] = r.addr; wd[i] = r.data;
            req[i] = 1'b1;
          end
        end
      end
    end
  end

  // reference model: one access at a time, 3 cycles, tie rules by last grant
  int phase = 0;
  int prio = 0;
  req_t cur;
  logic cur_own;
  logic [7:0] ref_data [256];
  bit ref_ok = 1'b0;
  exp_t me;
  always @(negedge clk) begin
    int w;
    if (!ref_ok) begin
      for (int i = 0; i < 256; i++) ref_data[i] = init_f(8'(i));
      ref_data[8'h33] = init_f(8'h33);
      ref_ok = 1'b1;
    end
    if (!rst_n) begin
      phase = 0;
      prio = 0;
      expq.delete();
    end else begin
      case (phase)
        0: begin
          w = 2;
          if (req[0] && req[1]) w = CPU_PRIO ? 0 : prio;
          else if (req[0]) w = 0;
          else if (req[1]) w = 1;
          chk("gnt", gnt, (w == 0) ? 2'b01 : (w == 1) ? 2'b10 : 2'b00);
          chk("idle_strobes", {ram_ae, ram_we, ram_oe, ram_rsel}, 4'b0000);
          if (w < 2) begin
            cur = '{we: we[w], sel: sel[w], addr: addr[w], data: wd[w]};
            cur_own = (w == 1);
            prio = (w == 0) ? 1 : 0;
            phase = 1;
          end
        end
        1: begin
          chk("addr_phase", {ram_ae, ram_we, ram_oe, ram_rsel}, 4'b1000);
          chk("addr_value", ram_a, cur.addr);
          chk("busy_gnt", gnt, 2'b00);
          phase = 2;
        end
        default: begin
          chk("data_addr", ram_a, cur.addr);
          chk("data_strobes", {ram_ae, ram_we, ram_oe, ram_rsel},
              {1'b0, cur.we & cur.sel, ~cur.we, cur.sel | cur.we});
          chk("busy_gnt", gnt, 2'b00);
          if (cur.we && cur.sel) chk("wdata", ram_wd, cur.data);
          me.own = cur_own;
          me.err = cur.we & ~cur.sel;
          me.rdv = ~cur.we;
          me.rd  = cur.sel ? ref_data[cur.addr] : prog_f(cur.addr);
          me.cyc = 32'(cyc + 1);
          if (cur.we && cur.sel) ref_data[cur.addr] = cur.data;
          expq.push_back(me);
          phase = 0;
        end
      endcase
    end
  end

  // monitor: pops expectations when Done appears
  logic [7:0] hold0 = 0, hold1 = 0;
  exp_t mo;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold0 = 0;
      hold1 = 0;
    end else begin
      if (expq.size() > 0 && expq[0].cyc < 32'(cyc)) begin
        mo = expq.pop_front();
        chk("done_missing", done, mo.own ? 2'b10 : 2'b01);
      end
      if (done != 2'b00) begin
        if (expq.size() == 0) begin
          chk("done_unexpected", done, 2'b00);
        end else begin
          mo = expq.pop_front();
          chk("done_cycle", 32'(cyc), mo.cyc);
          chk("done_owner", done, mo.own ? 2'b10 : 2'b01);
          chk("err", err, mo.err ? (mo.own ? 2'b10 : 2'b01) : 2'b00);
          if (mo.rdv && mo.own) hold1 = mo.rd;
          if (mo.rdv && !mo.own) hold0 = mo.rd;
        end
      end
      chk("rdata", {dbg_rd, cpu_rd}, {hold1, hold0});
    end
  end

  task automatic drain();
    int k = 0;
    while ((pq0.size() != 0 || pq1.size() != 0 || req != 2'b00 ||
            expq.size() != 0 || phase != 0) && k < 4000) begin
      @(negedge clk);
      k++;
    end
    chk("drain_pending", 32'(pq0.size() + pq1.size() + expq.size()), 0);
    repeat (2) @(negedge clk);
  endtask

  function automatic req_t rnd_req();
    req_t r;
    r.we = 1'($urandom);
    r.sel = 1'($urandom);
    r.addr = 8'($urandom_range(15));
    r.data = 8'($urandom);
    return r;
  endfunction

  initial begin
    int k;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", all_outs, 42'd0);
    rst_n = 1'b1;

    // reset in the middle of a write's DATA cycle
    pq0.push_back('{we: 1'b1, sel: 1'b1, addr: 8'h33, data: 8'h77});
    k = 0;
    @(negedge clk);
    while (!cpu_gnt && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("rst_grant", cpu_gnt, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("reset_mid", all_outs, 42'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    pq0.push_back('{we: 1'b0, sel: 1'b1, addr: 8'h33, data: 8'h00});
    drain();
    pq0.push_back('{we: 1'b1, sel: 1'b1, addr: 8'h12, data: 8'hA5});
    pq0.push_back('{we: 1'b0, sel: 1'b1, addr: 8'h12, data: 8'h00});
    drain();
    pq1.push_back('{we: 1'b1, sel: 1'b0, addr: 8'h05, data: 8'h5A});
    pq1.push_back('{we: 1'b0, sel: 1'b0, addr: 8'h05, data: 8'h00});
    drain();

    for (int i = 0; i < 6; i++) begin
      pq0.push_back(rnd_req());
      pq1.push_back(rnd_req());
    end
    drain();

    rate = 40;
    for (int i = 0; i < 150; i++) begin
      pq0.push_back(rnd_req());
      pq1.push_back(rnd_req());
    end
    drain();

    rate = 100;
    for (int i = 0; i < 20; i++) begin
      pq0.push_back(rnd_req());
      pq1.push_back(rnd_req());
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
